// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg -- shared definitions for the multi-cycle RISC-V control unit.
//   * state_t   : controller state encoding
//   * OPC_*     : major opcodes recognised in DECODE
//   * CC_*      : Concat_control (immediate-format select) encodings
//   * ctrl_t    : bundle of registered per-state control outputs
//   * ctrl_decode(): Moore output decode for a given state
package rv_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'd0,
        ST_FETCH    = 5'd1,
        ST_DECODE   = 5'd2,
        ST_MEM_ADDR = 5'd3,
        ST_MEM_RD   = 5'd4,
        ST_MEM_WR   = 5'd5,
        ST_MEM_WB   = 5'd6,
        ST_R_EX     = 5'd7,
        ST_I_EX     = 5'd8,
        ST_ALU_WB   = 5'd9,
        ST_BR_EX    = 5'd10,
        ST_JAL_EX   = 5'd11,
        ST_JALR_EX  = 5'd12,
        ST_JMP_WB   = 5'd13,
        ST_U_EX     = 5'd14,
        ST_U_WB     = 5'd15,
        ST_TRAP     = 5'd16
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] CC_NONE  = 3'b000;
    localparam logic [2:0] CC_U     = 3'b001;
    localparam logic [2:0] CC_J     = 3'b010;
    localparam logic [2:0] CC_I     = 3'b011;
    localparam logic [2:0] CC_B     = 3'b100;
    localparam logic [2:0] CC_LD    = 3'b101;
    localparam logic [2:0] CC_SHAMT = 3'b110;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src1;
        logic       alu_src2;
        logic       reg_write;
        logic       jal_or_jalr;
        logic       illegal;
        logic       fetch;      // qualifies IRWrite/PCWrite with IMemReady
        logic       alu_op_en;  // forwards opcode to ALUOp
        logic [2:0] concat;
    } ctrl_t;

    // Every field starts at zero and is raised only by the state that needs it.
    function automatic ctrl_t ctrl_decode(input state_t st, input logic is_load,
                                          input logic [2:0] funct3);
        ctrl_t c;
        c = '0;
        c.alu_op_en = (st != ST_IDLE) && (st != ST_TRAP);
        case (st)
            ST_FETCH:    begin c.mem_read = 1'b1; c.fetch = 1'b1; end
            ST_MEM_ADDR: begin c.alu_src2 = 1'b1; c.concat = is_load ? CC_LD : CC_I; end
            ST_MEM_RD:   c.mem_read = 1'b1;
            ST_MEM_WR:   c.mem_write = 1'b1;
            ST_MEM_WB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            // Shifts (funct3 x01) carry a shamt-style immediate.
            ST_I_EX:     begin c.alu_src2 = 1'b1;
                               c.concat = (funct3[1:0] == 2'b01) ? CC_SHAMT : CC_I; end
            ST_ALU_WB,
            ST_JMP_WB,
            ST_U_WB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            ST_BR_EX:    begin c.branch = 1'b1; c.concat = CC_B; end
            ST_JAL_EX:   begin c.alu_src1 = 1'b1; c.alu_src2 = 1'b1; c.jump = 1'b1;
                               c.concat = CC_J; end
            ST_JALR_EX:  begin c.alu_src2 = 1'b1; c.jump = 1'b1; c.jal_or_jalr = 1'b1;
                               c.concat = CC_I; end
            ST_U_EX:     begin c.alu_src1 = 1'b1; c.alu_src2 = 1'b1; c.concat = CC_U; end
            ST_TRAP:     c.illegal = 1'b1;
            default:     c.concat = CC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if -- memory handshake bundle between the control FSM and
// the instruction/data memory port.
//   IMemReady, DMemReady : memory -> controller ready strobes
//   MemRead, MemWrite    : controller -> memory access requests
//   BE                   : byte enables, XLEN/8 wide
// Modports: master (controller side), slave (memory side).
interface mc_control_fsm_if #(
    parameter int XLEN = 32
) ();
    logic                IMemReady;
    logic                DMemReady;
    logic                MemRead;
    logic                MemWrite;
    logic [XLEN/8-1:0]   BE;

    modport master (input IMemReady, DMemReady, output MemRead, MemWrite, BE);
    modport slave  (output IMemReady, DMemReady, input MemRead, MemWrite, BE);
endinterface

// File: rtl/mc_be_decode.sv
// mc_be_decode -- combinational byte-enable decode for loads/stores.
//   funct3  in  access size field of the instruction
//   be      out low-order byte enables (XLEN/8 wide)
//   illegal out size not supported at this XLEN
module mc_be_decode #(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    output logic [XLEN/8-1:0] be,
    output logic              illegal
);
    localparam int BW = XLEN / 8;

    logic [3:0] nbytes_s;

    // Map funct3 to an access size; doubleword and LWU exist only for RV64.
    always_comb begin
        nbytes_s = 4'd0;
        illegal  = 1'b0;
        case (funct3)
            3'b000, 3'b100: nbytes_s = 4'd1;
            3'b001, 3'b101: nbytes_s = 4'd2;
            3'b010:         nbytes_s = 4'd4;
            3'b110:         if (XLEN == 32) illegal = 1'b1; else nbytes_s = 4'd4;
            3'b011:         if (XLEN == 32) illegal = 1'b1; else nbytes_s = 4'(BW);
            default:        illegal = 1'b1;
        endcase
    end

    // Enable the lowest nbytes_s bytes.
    always_comb begin
        be = '0;
        for (int i = 0; i < BW; i++) begin
            be[i] = (i < int'(nbytes_s));
        end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multi-cycle RISC-V control unit (Moore FSM).
// Ports:
//   CLK, RST        clock; asynchronous active-high reset
//   opcode, funct3  from the instruction register
//   mem             mc_control_fsm_if.master: IMemReady/DMemReady in,
//                   MemRead/MemWrite/BE out
//   RegDst..IRWrite datapath controls, ALUOp, Concat_control
//   Illegal         sticky trap flag, cleared only by RST
//   CycleCnt, InstretCnt performance counters
// Macro CTRL_PERF_CNT_EN builds the counters; otherwise they read 0.
module mc_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    mc_control_fsm_if.master      mem,
    output logic                  RegDst,
    output logic                  Jump,
    output logic                  Branch,
    output logic                  MemtoReg,
    output logic                  ALUSrc1,
    output logic                  ALUSrc2,
    output logic                  RegWrite,
    output logic                  JALorJALR,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic [6:0]            ALUOp,
    output logic [2:0]            Concat_control,
    output logic                  Illegal,
    output logic [CNT_W-1:0]      CycleCnt,
    output logic [CNT_W-1:0]      InstretCnt
);
    state_t            state_r;
    state_t            next_s;
    ctrl_t             ctrl_r;
    logic [XLEN/8-1:0] be_r;
    logic [XLEN/8-1:0] be_s;
    logic              be_illegal_s;
    logic              is_load_s;

    assign is_load_s = (opcode == OPC_LOAD);

    mc_be_decode #(.XLEN(XLEN)) u_be_decode (
        .funct3  (funct3),
        .be      (be_s),
        .illegal (be_illegal_s)
    );

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:     next_s = ST_FETCH;
            ST_FETCH:    if (mem.IMemReady) next_s = ST_DECODE; else next_s = ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: next_s = ST_MEM_ADDR;
                    OPC_OP:              next_s = ST_R_EX;
                    OPC_OP_IMM:          next_s = ST_I_EX;
                    OPC_BRANCH:          next_s = ST_BR_EX;
                    OPC_JAL:             next_s = ST_JAL_EX;
                    OPC_JALR:            next_s = ST_JALR_EX;
                    OPC_LUI, OPC_AUIPC:  next_s = ST_U_EX;
                    default:             next_s = ST_TRAP;
                endcase
            end
            // Stores only allow funct3 000-011, hence the funct3[2] test.
            ST_MEM_ADDR: begin
                if (be_illegal_s || (!is_load_s && funct3[2])) next_s = ST_TRAP;
                else if (is_load_s)                             next_s = ST_MEM_RD;
                else                                            next_s = ST_MEM_WR;
            end
            ST_MEM_RD:   if (mem.DMemReady) next_s = ST_MEM_WB; else next_s = ST_MEM_RD;
            ST_MEM_WR:   if (mem.DMemReady) next_s = ST_FETCH;  else next_s = ST_MEM_WR;
            ST_R_EX,
            ST_I_EX:     next_s = ST_ALU_WB;
            ST_JAL_EX,
            ST_JALR_EX:  next_s = ST_JMP_WB;
            ST_U_EX:     next_s = ST_U_WB;
            ST_MEM_WB,
            ST_ALU_WB,
            ST_BR_EX,
            ST_JMP_WB,
            ST_U_WB:     next_s = ST_FETCH;
            ST_TRAP:     next_s = ST_TRAP;
            default:     next_s = ST_TRAP;
        endcase
    end

    // State register plus outputs registered from the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            ctrl_r  <= '0;
            be_r    <= '0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= ctrl_decode(next_s, is_load_s, funct3);
            be_r    <= ((next_s == ST_MEM_RD) || (next_s == ST_MEM_WR)) ? be_s : '0;
        end
    end

    assign RegDst         = ctrl_r.reg_dst;
    assign Jump           = ctrl_r.jump;
    assign Branch         = ctrl_r.branch;
    assign MemtoReg       = ctrl_r.mem_to_reg;
    assign ALUSrc1        = ctrl_r.alu_src1;
    assign ALUSrc2        = ctrl_r.alu_src2;
    assign RegWrite       = ctrl_r.reg_write;
    assign JALorJALR      = ctrl_r.jal_or_jalr;
    assign Concat_control = ctrl_r.concat;
    assign Illegal        = ctrl_r.illegal;
    assign mem.MemRead    = ctrl_r.mem_read;
    assign mem.MemWrite   = ctrl_r.mem_write;
    assign mem.BE         = be_r;
    // The IR is loaded at the end of FETCH, so ALUOp follows opcode live
    // rather than a copy taken before the instruction arrived.
    assign ALUOp          = ctrl_r.alu_op_en ? opcode : 7'd0;
    // Write strobes fire only in the fetch cycle where the memory delivers.
    assign IRWrite        = ctrl_r.fetch & mem.IMemReady;
    assign PCWrite        = ctrl_r.fetch & mem.IMemReady;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;

    // Cycle count freezes in TRAP; an instruction retires on re-entering FETCH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
        end else begin
            if (state_r != ST_TRAP) begin
                cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((next_s == ST_FETCH) && (state_r != ST_FETCH) && (state_r != ST_IDLE)) begin
                instret_cnt_r <= instret_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign CycleCnt   = cycle_cnt_r;
    assign InstretCnt = instret_cnt_r;
`else
    assign CycleCnt   = '0;
    assign InstretCnt = '0;
`endif
endmodule
